// File: rtl/devbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : devbus_arbiter
// Description : Two-master round-robin arbiter for the shared device
//               instruction bus. Supports bus lock with a starvation limit.
// Revision    : 1.0 - initial release
// ============================================================================
module devbus_arbiter #(
    parameter int INST_SIZE = 12,
    parameter int WEN_SIZE  = 8,
    parameter int LOCK_MAX  = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [INST_SIZE-1:0] inst0,
    input  logic [WEN_SIZE-1:0]  wen0,
    input  logic                 valid0,
    input  logic                 lock0,
    output logic                 ready0,
    input  logic [INST_SIZE-1:0] inst1,
    input  logic [WEN_SIZE-1:0]  wen1,
    input  logic                 valid1,
    input  logic                 lock1,
    output logic                 ready1,
    output logic [INST_SIZE-1:0] oreg,
    output logic [WEN_SIZE-1:0]  oreg_wen,
    output logic                 owner,
    output logic                 locked
);

    localparam logic [7:0] c_lock_max = 8'(LOCK_MAX);

    typedef enum logic [0:0] {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [7:0]             r_cnt;
    logic [7:0]             w_cnt_nxt;
    logic                   r_ptr;
    logic                   r_owner;
    logic [INST_SIZE-1:0]   r_oreg;
    logic [WEN_SIZE-1:0]    r_oreg_wen;
    logic                   w_grant0;
    logic                   w_grant1;
    logic                   w_owner_valid;
    logic                   w_other_valid;
    logic                   w_acc;
    logic                   w_sel;
    logic                   w_sel_lock;

    always_comb begin
        w_grant0      = 1'b0;
        w_grant1      = 1'b0;
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_owner_valid = r_owner ? valid1 : valid0;
        w_other_valid = r_owner ? valid0 : valid1;
        case (r_state)
            ST_UNLOCKED: begin
                // Contention goes to the master that did not win last time
                if (valid0 && valid1) begin
                    w_grant0 = r_ptr;
                    w_grant1 = ~r_ptr;
                end else begin
                    w_grant0 = valid0;
                    w_grant1 = valid1;
                end
            end
            ST_LOCKED: begin
                if (!w_owner_valid || (r_cnt == c_lock_max && w_other_valid)) begin
                    w_state_nxt = ST_UNLOCKED;
                    w_cnt_nxt   = 8'd0;
                end else begin
                    w_grant0 = ~r_owner;
                    w_grant1 = r_owner;
                end
            end
            default: begin
                w_state_nxt = ST_UNLOCKED;
                w_cnt_nxt   = 8'd0;
            end
        endcase

        ready0     = reset & valid0 & w_grant0;
        ready1     = reset & valid1 & w_grant1;
        w_acc      = ready0 | ready1;
        w_sel      = ready1;
        w_sel_lock = w_sel ? lock1 : lock0;

        if (w_acc) begin
            if (w_sel_lock) begin
                w_state_nxt = ST_LOCKED;
                // Counter saturates while nobody else is waiting
                if (r_state == ST_UNLOCKED)
                    w_cnt_nxt = 8'd1;
                else if (r_cnt == c_lock_max)
                    w_cnt_nxt = r_cnt;
                else
                    w_cnt_nxt = r_cnt + 8'd1;
            end else begin
                w_state_nxt = ST_UNLOCKED;
                w_cnt_nxt   = 8'd0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_UNLOCKED;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_oreg     <= '0;
            r_oreg_wen <= '0;
            r_owner    <= 1'b0;
            r_ptr      <= 1'b1;
        end else if (w_acc) begin
            r_oreg     <= w_sel ? inst1 : inst0;
            r_oreg_wen <= w_sel ? wen1 : wen0;
            r_owner    <= w_sel;
            r_ptr      <= w_sel;
        end else begin
            r_oreg_wen <= '0;
        end
    end

    assign oreg     = r_oreg;
    assign oreg_wen = r_oreg_wen;
    assign owner    = r_owner;
    assign locked   = (r_state == ST_LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_devbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_devbus_arbiter
// Description : Self-checking bench for devbus_arbiter (reference model plus
//               directed sequences).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_devbus_arbiter;

    localparam int c_lock_max = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] inst0, inst1;
    logic [7:0]  wen0, wen1;
    logic        valid0, valid1, lock0, lock1;
    logic        ready0, ready1;
    logic [11:0] oreg;
    logic [7:0]  oreg_wen;
    logic        owner, locked;

    int checks = 0;
    int errors = 0;

    devbus_arbiter #(.INST_SIZE(12), .WEN_SIZE(8), .LOCK_MAX(c_lock_max)) dut (
        .clock(clock), .reset(reset),
        .inst0(inst0), .wen0(wen0), .valid0(valid0), .lock0(lock0), .ready0(ready0),
        .inst1(inst1), .wen1(wen1), .valid1(valid1), .lock1(lock1), .ready1(ready1),
        .oreg(oreg), .oreg_wen(oreg_wen), .owner(owner), .locked(locked)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference model: bus ownership tracked as plain integers
    int          m_locked = 0;
    int          m_count  = 0;
    int          m_last   = 1;
    logic [11:0] e_oreg   = '0;
    logic [7:0]  e_wen    = '0;
    int          e_owner  = 0;

    always @(negedge clock) begin
        int          v[2];
        int          lk[2];
        logic [11:0] in_inst[2];
        logic [7:0]  in_wen[2];
        int          g;
        v[0] = int'(valid0); v[1] = int'(valid1);
        lk[0] = int'(lock0); lk[1] = int'(lock1);
        in_inst[0] = inst0;  in_inst[1] = inst1;
        in_wen[0] = wen0;    in_wen[1] = wen1;
        if (!reset) begin
            m_locked = 0; m_count = 0; m_last = 1;
            e_oreg = '0; e_wen = '0; e_owner = 0;
            chk("rst_ready0", 32'(ready0), 0);
            chk("rst_ready1", 32'(ready1), 0);
            chk("rst_oreg", 32'(oreg), 0);
            chk("rst_wen", 32'(oreg_wen), 0);
        end else begin
            chk("m_oreg", 32'(oreg), 32'(e_oreg));
            chk("m_wen", 32'(oreg_wen), 32'(e_wen));
            chk("m_owner", 32'(owner), 32'(e_owner));
            chk("m_locked", 32'(locked), 32'(m_locked));
            g = -1;
            if (m_locked == 0) begin
                if (v[0] + v[1] == 2) g = 1 - m_last;
                else if (v[0] == 1)   g = 0;
                else if (v[1] == 1)   g = 1;
            end else if (v[e_owner] == 1 &&
                         !(m_count == c_lock_max && v[1 - e_owner] == 1)) begin
                g = e_owner;
            end
            chk("m_ready0", 32'(ready0), 32'(g == 0));
            chk("m_ready1", 32'(ready1), 32'(g == 1));
            if (g >= 0) begin
                e_oreg  = in_inst[g];
                e_wen   = in_wen[g];
                e_owner = g;
                m_last  = g;
                if (lk[g] == 1) begin
                    m_count  = (m_locked == 0) ? 1 :
                               (m_count + 1 > c_lock_max ? c_lock_max : m_count + 1);
                    m_locked = 1;
                end else begin
                    m_locked = 0;
                    m_count  = 0;
                end
            end else begin
                e_wen = '0;
                if (m_locked == 1) begin
                    m_locked = 0;
                    m_count  = 0;
                end
            end
        end
    end

    int exp_r0[7] = '{1, 1, 1, 1, 0, 0, 1};
    int exp_r1[7] = '{0, 0, 0, 0, 0, 1, 0};

    initial begin
        reset = 1'b0;
        inst0 = '0; inst1 = '0; wen0 = '0; wen1 = '0;
        valid0 = 1'b0; valid1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
        tick(); tick();
        valid0 = 1'b1;
        #1;
        chk("ready_in_reset", 32'(ready0), 0);
        chk("reset_locked", 32'(locked), 0);
        valid0 = 1'b0;
        tick();
        reset = 1'b1;

        // Single transfer and its one-cycle pulse
        valid0 = 1'b1; inst0 = 12'h1A5; wen0 = 8'h01;
        #1;
        chk("t1_ready0", 32'(ready0), 1);
        tick();
        valid0 = 1'b0;
        chk("t1_oreg", 32'(oreg), 32'h1A5);
        chk("t1_wen", 32'(oreg_wen), 32'h01);
        chk("t1_owner", 32'(owner), 0);
        tick();
        chk("t1_wen_clr", 32'(oreg_wen), 0);

        // Round-robin alternation from a fresh reset
        reset = 1'b0; tick(); reset = 1'b1;
        valid0 = 1'b1; inst0 = 12'h100; wen0 = 8'h02;
        valid1 = 1'b1; inst1 = 12'h200; wen1 = 8'h04;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rr_owner", 32'(owner), 32'(i % 2));
            chk("rr_wen", 32'(oreg_wen), (i % 2 == 1) ? 32'h04 : 32'h02);
        end
        valid0 = 1'b0; valid1 = 1'b0;
        tick();

        // Master 1 locked sequence while master 0 waits
        valid0 = 1'b1; inst0 = 12'h011; wen0 = 8'h08;
        tick();
        valid1 = 1'b1; inst1 = 12'h0A1; wen1 = 8'h10;
        for (int i = 0; i < 4; i++) begin
            lock1 = (i < 3);
            #1;
            chk("lk_ready0", 32'(ready0), 0);
            chk("lk_ready1", 32'(ready1), 1);
            tick();
            chk("lk_locked", 32'(locked), 32'(i < 3));
            chk("lk_owner", 32'(owner), 1);
        end
        valid1 = 1'b0; lock1 = 1'b0;
        #1;
        chk("lk_after_ready0", 32'(ready0), 1);
        tick();
        valid0 = 1'b0;
        tick();

        // Starvation limit with LOCK_MAX = 4
        reset = 1'b0; tick(); reset = 1'b1;
        valid0 = 1'b1; lock0 = 1'b1; inst0 = 12'h0C0; wen0 = 8'h40;
        valid1 = 1'b1; lock1 = 1'b0; inst1 = 12'h0D0; wen1 = 8'h80;
        for (int i = 0; i < 7; i++) begin
            #1;
            chk("st_ready0", 32'(ready0), 32'(exp_r0[i]));
            chk("st_ready1", 32'(ready1), 32'(exp_r1[i]));
            tick();
        end
        chk("st_relock", 32'(locked), 1);

        // Zero-enable transfer ends the lock, no pulse
        valid1 = 1'b0; lock0 = 1'b0; inst0 = 12'h3FF; wen0 = 8'h00;
        #1;
        chk("z_ready0", 32'(ready0), 1);
        tick();
        chk("z_oreg", 32'(oreg), 32'h3FF);
        chk("z_wen", 32'(oreg_wen), 0);
        chk("z_locked", 32'(locked), 0);
        valid0 = 1'b0;
        tick();

        // Reset in the middle of a lock held by master 0
        valid0 = 1'b1; lock0 = 1'b1; inst0 = 12'h055; wen0 = 8'h20;
        tick(); tick();
        #2;
        reset = 1'b0;
        #1;
        chk("mr_oreg", 32'(oreg), 0);
        chk("mr_wen", 32'(oreg_wen), 0);
        chk("mr_locked", 32'(locked), 0);
        chk("mr_ready0", 32'(ready0), 0);
        tick();
        reset = 1'b1;
        valid1 = 1'b1; lock0 = 1'b0;
        #1;
        chk("mr_first_r0", 32'(ready0), 1);
        chk("mr_first_r1", 32'(ready1), 0);
        tick();
        chk("mr_owner", 32'(owner), 0);
        valid0 = 1'b0; valid1 = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
